// File: rtl/priority_encoder.sv
// Registered 8-to-3 priority encoder: request h wins, a loses.
// Index and valid are captured on the rising edge; async active-low clear.
module priority_encoder (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic e,
   input  logic f,
   input  logic g,
   input  logic h,
   output logic out0,
   output logic out1,
   output logic out2,
   output logic valid
);

   logic [7:0] req;
   logic [2:0] idx;
   logic       any;
   logic [2:0] idx_q;
   logic       any_q;

   assign req = {h, g, f, e, d, c, b, a};

   // Ascending scan so the last (highest) set bit overrides lower ones.
   always_comb begin
      idx = 3'b000;
      any = |req;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) begin
            idx = 3'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= 3'b000;
         any_q <= 1'b0;
      end else begin
         idx_q <= idx;
         any_q <= any;
      end
   end

   assign out0  = idx_q[0];
   assign out1  = idx_q[1];
   assign out2  = idx_q[2];
   assign valid = any_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: driver queues model results,
// a monitor pops one per clock and compares against the registered outputs.
module tb_priority_encoder;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic a, b, c, d, e, f, g, h;
   logic out0, out1, out2, valid;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_q[$];

   priority_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .e     (e),
      .f     (f),
      .g     (g),
      .h     (h),
      .out0  (out0),
      .out1  (out1),
      .out2  (out2),
      .valid (valid)
   );

   always #5 clk = ~clk;

   // Reference: {valid, index}; index of highest set bit is floor(log2(v)).
   function automatic logic [3:0] model(input logic [7:0] v);
      int idx;
      if (v == 8'h00) return 4'b0000;
      idx = $clog2(int'(v) + 1) - 1;
      return {1'b1, idx[2:0]};
   endfunction

   function automatic logic [3:0] observed();
      return {valid, out2, out1, out0};
   endfunction

   task automatic check(input string name, input logic [3:0] act,
                        input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got valid/idx=%b/%b expected %b/%b at %0t",
                  name, act[3], act[2:0], req[3], req[2:0], $time);
      end
   endtask

   task automatic set_in(input logic [7:0] v);
      {h, g, f, e, d, c, b, a} = v;
   endtask

   task automatic drive(input logic [7:0] v);
      @(negedge clk);
      set_in(v);
      exp_q.push_back(model(v));
   endtask

   // Monitor: each edge with a queued expectation produces one result.
   always @(posedge clk) begin
      logic [3:0] ex;
      #1;
      if (rst_n && exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         check("encode", observed(), ex);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [7:0] dir [7];
      dir = '{8'h00, 8'h01, 8'h20, 8'h80, 8'h6B, 8'h06, 8'hFF};

      set_in(8'hFF);
      @(posedge clk);
      #2;
      // Async clear: no clock edge between assert and check.
      rst_n = 1'b0;
      #1;
      check("reset_async", observed(), 4'b0000);
      @(posedge clk);
      #1;
      check("reset_hold", observed(), 4'b0000);

      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(8'hFF));
      @(posedge clk);
      #2;
      check("reset_release", observed(), 4'b1111);

      foreach (dir[i]) drive(dir[i]);

      for (int v = 0; v < 256; v++) drive(8'(v));

      // Latency/hold: inputs changed mid-cycle must not reach outputs.
      drive(8'h01);
      @(posedge clk);
      #3;
      set_in(8'h80);
      #1;
      check("hold_mid", observed(), model(8'h01));
      @(negedge clk);
      check("hold_neg", observed(), model(8'h01));
      @(posedge clk);
      #1;
      check("hold_next", observed(), model(8'h80));

      for (int i = 0; i < 200; i++) begin
         drive(8'($urandom_range(0, 255)));
         if (i == 100) begin
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check("reset_mid", observed(), 4'b0000);
            @(posedge clk);
            #1;
            check("reset_mid_hold", observed(), 4'b0000);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results pending, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
